// File: rtl/bp_bedrock_beat_sequencer.sv
// Turns one BedRock header (size, address) into a stream of per-beat descriptors.
// Define BP_BEDROCK_BEAT_SEQ_WRAP_EN for critical-beat-first ordering; the default is linear.

package bp_bedrock_beat_seq_pkg;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'b000,
      e_bedrock_msg_size_2   = 3'b001,
      e_bedrock_msg_size_4   = 3'b010,
      e_bedrock_msg_size_8   = 3'b011,
      e_bedrock_msg_size_16  = 3'b100,
      e_bedrock_msg_size_32  = 3'b101,
      e_bedrock_msg_size_64  = 3'b110,
      e_bedrock_msg_size_128 = 3'b111
   } bp_bedrock_msg_size_e;

endpackage

module bp_bedrock_beat_sequencer
   import bp_bedrock_beat_seq_pkg::*;
#(
   parameter int beat_width_p  = 64,
   parameter int len_width_p   = 4,
   parameter int paddr_width_p = 40
)
(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  bp_bedrock_msg_size_e     size_i,
   input  logic [paddr_width_p-1:0] addr_i,
   input  logic                     v_i,
   output logic                     ready_and_o,
   output logic                     v_o,
   input  logic                     yumi_i,
   output logic [paddr_width_p-1:0] addr_o,
   output logic [len_width_p-1:0]   cnt_o,
   output logic [len_width_p-1:0]   len_o,
   output logic                     first_o,
   output logic                     last_o
);

   localparam int beat_bytes_lp    = beat_width_p / 8;
   localparam int lg_beat_bytes_lp = $clog2(beat_bytes_lp);
   localparam int max_len_lp       = ((1024 + beat_width_p - 1) / beat_width_p) - 1;

   if ((beat_width_p & (beat_width_p - 1)) != 0) begin : g_bad_pow2
      $error("beat_width_p must be a power of two");
   end
   if (beat_width_p < 8) begin : g_bad_min
      $error("beat_width_p must be at least 8");
   end
   if (((1 << len_width_p) - 1) < max_len_lp) begin : g_bad_len
      $error("len_width_p too small for a 128-byte message");
   end

   typedef enum logic {e_ready, e_busy} state_e;

   state_e                   state_r;
   logic [paddr_width_p-1:0] base_r;
   logic [len_width_p-1:0]   start_r;
   logic                     sub_r;

   logic                     accept;
   logic [len_width_p-1:0]   new_len;
   logic [len_width_p-1:0]   new_start;
   logic                     new_sub;
   logic [len_width_p-1:0]   next_cnt;

   // All 3-bit size codes are defined; anything at or below one beat is a single beat.
   function automatic logic [len_width_p-1:0] size_to_len(input bp_bedrock_msg_size_e size);
      int lg_msg;
      lg_msg = int'(size);
      if (lg_msg <= lg_beat_bytes_lp)
         return '0;
      return len_width_p'((1 << (lg_msg - lg_beat_bytes_lp)) - 1);
   endfunction

   // len+1 is a power of two, so masking with len gives the modulo wrap inside the block.
   function automatic logic [paddr_width_p-1:0] beat_addr
      (input logic [paddr_width_p-1:0] base,
       input logic [len_width_p-1:0]   len,
       input logic [len_width_p-1:0]   start,
       input logic [len_width_p-1:0]   k,
       input logic                     sub);
      logic [paddr_width_p-1:0] block_mask;
      logic [len_width_p-1:0]   idx;
      block_mask = (paddr_width_p'(len) << lg_beat_bytes_lp)
                 | paddr_width_p'(beat_bytes_lp - 1);
      idx = (start + k) & len;
      if (sub)
         return base;
      return (base & ~block_mask) | (paddr_width_p'(idx) << lg_beat_bytes_lp);
   endfunction

   assign v_o = (state_r == e_busy);

   always_comb begin
      ready_and_o = (state_r == e_ready) | (v_o & yumi_i & last_o);
      accept      = v_i & ready_and_o;
      new_len     = size_to_len(size_i);
      new_sub     = (int'(size_i) <= lg_beat_bytes_lp);
`ifdef BP_BEDROCK_BEAT_SEQ_WRAP_EN
      new_start   = len_width_p'(addr_i >> lg_beat_bytes_lp) & new_len;
`else
      new_start   = '0;
`endif
      next_cnt    = cnt_o + 1'b1;
   end

   // A new header wins over retiring the last beat, which gives bubble-free back-to-back messages.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_ready;
         base_r  <= '0;
         start_r <= '0;
         sub_r   <= 1'b0;
         addr_o  <= '0;
         cnt_o   <= '0;
         len_o   <= '0;
         first_o <= 1'b0;
         last_o  <= 1'b0;
      end else if (accept) begin
         state_r <= e_busy;
         base_r  <= addr_i;
         start_r <= new_start;
         sub_r   <= new_sub;
         addr_o  <= beat_addr(addr_i, new_len, new_start, '0, new_sub);
         cnt_o   <= '0;
         len_o   <= new_len;
         first_o <= 1'b1;
         last_o  <= (new_len == '0);
      end else if (v_o && yumi_i) begin
         if (!last_o) begin
            addr_o  <= beat_addr(base_r, len_o, start_r, next_cnt, sub_r);
            cnt_o   <= next_cnt;
            first_o <= 1'b0;
            last_o  <= (next_cnt == len_o);
         end else begin
            state_r <= e_ready;
         end
      end
   end

endmodule

// File: tb/tb_bp_bedrock_beat_sequencer.sv
// Directed, table-driven bench for the beat sequencer (64-bit beats) plus a 512-bit instance.

module tb_bp_bedrock_beat_sequencer;
   import bp_bedrock_beat_seq_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset_i;
   bp_bedrock_msg_size_e size_i;
   logic [39:0]          addr_i;
   logic                 v_i, yumi_i;
   logic                 ready_and_o, v_o, first_o, last_o;
   logic [39:0]          addr_o;
   logic [3:0]           cnt_o, len_o;

   bp_bedrock_msg_size_e size2_i;
   logic [39:0]          addr2_i;
   logic                 v2_i, yumi2_i;
   logic                 ready2_o, v2_o, first2_o, last2_o;
   logic [39:0]          addr2_o;
   logic [3:0]           cnt2_o, len2_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bp_bedrock_beat_sequencer #(.beat_width_p(64), .len_width_p(4), .paddr_width_p(40)) dut (
      .clk_i(clk), .reset_i(reset_i), .size_i(size_i), .addr_i(addr_i), .v_i(v_i),
      .ready_and_o(ready_and_o), .v_o(v_o), .yumi_i(yumi_i), .addr_o(addr_o),
      .cnt_o(cnt_o), .len_o(len_o), .first_o(first_o), .last_o(last_o));

   bp_bedrock_beat_sequencer #(.beat_width_p(512), .len_width_p(4), .paddr_width_p(40)) dut512 (
      .clk_i(clk), .reset_i(reset_i), .size_i(size2_i), .addr_i(addr2_i), .v_i(v2_i),
      .ready_and_o(ready2_o), .v_o(v2_o), .yumi_i(yumi2_i), .addr_o(addr2_o),
      .cnt_o(cnt2_o), .len_o(len2_o), .first_o(first2_o), .last_o(last2_o));

   typedef struct {
      logic                 rst, v, yumi;
      bp_bedrock_msg_size_e size;
      logic [39:0]          addr;
      logic                 chk_all, e_v, e_ready;
      logic [39:0]          e_addr;
      logic [3:0]           e_cnt, e_len;
      logic                 e_first, e_last;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic v, input bp_bedrock_msg_size_e size,
                               input logic [39:0] addr, input logic yumi, input logic chk_all,
                               input logic e_v, input logic e_ready, input logic [39:0] e_addr,
                               input int e_cnt, input int e_len, input logic e_first,
                               input logic e_last);
      vec_t r;
      r.rst = rst; r.v = v; r.size = size; r.addr = addr; r.yumi = yumi;
      r.chk_all = chk_all; r.e_v = e_v; r.e_ready = e_ready; r.e_addr = e_addr;
      r.e_cnt = 4'(e_cnt); r.e_len = 4'(e_len); r.e_first = e_first; r.e_last = e_last;
      return r;
   endfunction

   function automatic vec_t idle();
      return mk(0, 0, e_bedrock_msg_size_1, 40'h0, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0);
   endfunction

   task automatic check_field(input string name, input int row, input logic [39:0] act,
                              input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t r);
      reset_i = r.rst;
      v_i     = r.v;
      size_i  = r.size;
      addr_i  = r.addr;
      yumi_i  = r.yumi;
   endtask

   task automatic check_output(input vec_t r, input int row);
      check_field("v_o", row, 40'(v_o), 40'(r.e_v));
      check_field("ready_and_o", row, 40'(ready_and_o), 40'(r.e_ready));
      if (r.e_v || r.chk_all) begin
         check_field("addr_o", row, addr_o, r.e_addr);
         check_field("cnt_o", row, 40'(cnt_o), 40'(r.e_cnt));
         check_field("len_o", row, 40'(len_o), 40'(r.e_len));
         check_field("first_o", row, 40'(first_o), 40'(r.e_first));
         check_field("last_o", row, 40'(last_o), 40'(r.e_last));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [39:0] a;
      logic [39:0] e0, e1;

      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; size_i = e_bedrock_msg_size_1; addr_i = '0;
      v2_i = 1'b0; yumi2_i = 1'b0; size2_i = e_bedrock_msg_size_1; addr2_i = '0;
      repeat (3) @(posedge clk);

      // Reset state: everything zero, header port open
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 0, 1, 0, 1, 40'h0, 0, 0, 0, 0));

      // size_64 at 0x1010, yumi always high
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_64, 40'h1010, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) begin
`ifdef BP_BEDROCK_BEAT_SEQ_WRAP_EN
         a = 40'h1000 + 40'(((2 + k) % 8) * 8);
`else
         a = 40'h1000 + 40'(k * 8);
`endif
         vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, (k == 7), a, k, 7,
                           (k == 0), (k == 7)));
      end
      vecs.push_back(idle());

      // size_4 at 0x2003: one sub-beat, ready while it is consumed
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_4, 40'h2003, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 1, 40'h2003, 0, 0, 1, 1));
      vecs.push_back(idle());

      // Back-to-back size_16 at 0x0 and 0x40 with no bubble
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_16, 40'h0, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 0, 40'h0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_16, 40'h40, 1, 0, 1, 1, 40'h8, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 0, 40'h40, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 1, 40'h48, 1, 1, 0, 1));
      vecs.push_back(idle());

      // size_32 at 0x3000 held under backpressure, then drained
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_32, 40'h3000, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 0, 0, 1, 0, 40'h3000, 0, 3, 1, 0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, (k == 3),
                           40'h3000 + 40'(k * 8), k, 3, (k == 0), (k == 3)));
      vecs.push_back(idle());

      // Reset on beat 2 of a size_64 message, then a size_8 header
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_64, 40'h4000, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 0, 40'h4000, 0, 7, 1, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 0, 40'h4008, 1, 7, 0, 0));
      vecs.push_back(mk(1, 0, e_bedrock_msg_size_1, 40'h0, 0, 0, 1, 0, 40'h4010, 2, 7, 0, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 0, 1, 0, 1, 40'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, e_bedrock_msg_size_8, 40'h5008, 0, 0, 0, 1, 40'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, e_bedrock_msg_size_1, 40'h0, 1, 0, 1, 1, 40'h5008, 0, 0, 1, 1));
      vecs.push_back(idle());

      foreach (vecs[i]) begin
         step();
         apply_stimulus(vecs[i]);
         #1;
         check_output(vecs[i], i);
      end

      // 512-bit beats: size_128 gives two beats, size_64 gives one unmodified beat
`ifdef BP_BEDROCK_BEAT_SEQ_WRAP_EN
      e0 = 40'h8040; e1 = 40'h8000;
`else
      e0 = 40'h8000; e1 = 40'h8040;
`endif
      step();
      v2_i = 1'b1; size2_i = e_bedrock_msg_size_128; addr2_i = 40'h8040; yumi2_i = 1'b0;
      #1;
      check_field("w512 idle v_o", 100, 40'(v2_o), 40'h0);
      check_field("w512 idle ready", 100, 40'(ready2_o), 40'h1);
      step();
      v2_i = 1'b0; yumi2_i = 1'b1;
      #1;
      check_field("w512 b0 v_o", 101, 40'(v2_o), 40'h1);
      check_field("w512 b0 addr", 101, addr2_o, e0);
      check_field("w512 b0 len", 101, 40'(len2_o), 40'h1);
      check_field("w512 b0 first", 101, 40'(first2_o), 40'h1);
      check_field("w512 b0 last", 101, 40'(last2_o), 40'h0);
      step();
      #1;
      check_field("w512 b1 addr", 102, addr2_o, e1);
      check_field("w512 b1 cnt", 102, 40'(cnt2_o), 40'h1);
      check_field("w512 b1 last", 102, 40'(last2_o), 40'h1);
      check_field("w512 b1 ready", 102, 40'(ready2_o), 40'h1);
      step();
      v2_i = 1'b1; size2_i = e_bedrock_msg_size_64; addr2_i = 40'h9020; yumi2_i = 1'b0;
      #1;
      check_field("w512 gap v_o", 103, 40'(v2_o), 40'h0);
      step();
      v2_i = 1'b0; yumi2_i = 1'b1;
      #1;
      check_field("w512 s64 v_o", 104, 40'(v2_o), 40'h1);
      check_field("w512 s64 addr", 104, addr2_o, 40'h9020);
      check_field("w512 s64 len", 104, 40'(len2_o), 40'h0);
      check_field("w512 s64 first", 104, 40'(first2_o), 40'h1);
      check_field("w512 s64 last", 104, 40'(last2_o), 40'h1);
      step();
      yumi2_i = 1'b0;
      #1;
      check_field("w512 end v_o", 105, 40'(v2_o), 40'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
